// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined RV32I main control: opcodes, ALUOp and
// writeback-select codes, and the per-stage control bundle layouts.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int ALUOP_BITS = 2;
    localparam logic [ALUOP_BITS-1:0] ALU_ADD   = 2'b00;
    localparam logic [ALUOP_BITS-1:0] ALU_SUB   = 2'b01;
    localparam logic [ALUOP_BITS-1:0] ALU_FUNCT = 2'b10;
    localparam logic [ALUOP_BITS-1:0] ALU_PASSB = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic                  branch;
        logic                  jump;
        logic                  jalr;
        logic                  mem_read;
        logic                  mem_write;
        logic [1:0]            wb_sel;
        logic [ALUOP_BITS-1:0] aluop;
        logic                  alusrc;
        logic                  asel_pc;
        logic                  regwrite;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Later stages only carry the fields they still consume.
    typedef struct packed {
        logic       valid;
        logic       mem_read;
        logic       mem_write;
        logic       regwrite;
        logic [1:0] wb_sel;
    } mem_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic [1:0] wb_sel;
    } wb_ctrl_t;

    function automatic ctrl_t mk_ctrl(
        input logic                  branch,
        input logic                  jump,
        input logic                  jalr,
        input logic                  mem_read,
        input logic                  mem_write,
        input logic [1:0]            wb_sel,
        input logic [ALUOP_BITS-1:0] aluop,
        input logic                  alusrc,
        input logic                  asel_pc,
        input logic                  regwrite
    );
        mk_ctrl = '{valid: 1'b1, branch: branch, jump: jump, jalr: jalr,
                    mem_read: mem_read, mem_write: mem_write, wb_sel: wb_sel,
                    aluop: aluop, alusrc: alusrc, asel_pc: asel_pc,
                    regwrite: regwrite};
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decode: opcode to control bundle, source-register
// usage for hazard detection, and the illegal-opcode flag.
module ctrl_decode import ctrl_pkg::*; #(
    parameter int REG_AW = 5
) (
    input  logic [6:0]        opcode,
    input  logic [REG_AW-1:0] rd,
    output ctrl_t             ctrl,
    output logic              uses_rs1,
    output logic              uses_rs2,
    output logic              illegal
);

    always_comb begin
        ctrl     = CTRL_BUBBLE;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WB_ALU, ALU_FUNCT, 1'b0, 1'b0, 1'b1);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IMM: begin
                ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WB_ALU, ALU_FUNCT, 1'b1, 1'b0, 1'b1);
                uses_rs1 = 1'b1;
            end
            OP_LOAD: begin
                ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, WB_MEM, ALU_ADD, 1'b1, 1'b0, 1'b1);
                uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, WB_ALU, ALU_ADD, 1'b1, 1'b0, 1'b0);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                ctrl = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, WB_ALU, ALU_SUB, 1'b0, 1'b0, 1'b0);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_JAL: begin
                ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, WB_PC4, ALU_ADD, 1'b1, 1'b1, 1'b1);
            end
            OP_JALR: begin
                ctrl = mk_ctrl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, WB_PC4, ALU_ADD, 1'b1, 1'b0, 1'b1);
                uses_rs1 = 1'b1;
            end
            OP_LUI: begin
                ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WB_ALU, ALU_PASSB, 1'b1, 1'b0, 1'b1);
            end
            OP_AUIPC: begin
                ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, WB_ALU, ALU_ADD, 1'b1, 1'b1, 1'b1);
            end
            default: illegal = 1'b1;
        endcase
        // Writes to x0 are architecturally discarded; drop them here.
        if (rd == '0) ctrl.regwrite = 1'b0;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined main control: decodes in ID, carries the bundle through
// ID/EX, EX/MEM and MEM/WB, and handles load-use stalls and EX flushes.
module ctrl_pipe import ctrl_pkg::*; #(
    parameter int REG_AW       = 5,
    parameter int ALUOP_W      = 2,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid_i,
    input  logic [6:0]         id_opcode_i,
    input  logic [REG_AW-1:0]  id_rs1_i,
    input  logic [REG_AW-1:0]  id_rs2_i,
    input  logic [REG_AW-1:0]  id_rd_i,
    input  logic               flush_i,
    output logic               stall_id_o,
    output logic               ex_valid_o,
    output logic               ex_branch_o,
    output logic               ex_jump_o,
    output logic               ex_jalr_o,
    output logic               ex_alusrc_o,
    output logic               ex_asel_pc_o,
    output logic [ALUOP_W-1:0] ex_aluop_o,
    output logic [REG_AW-1:0]  ex_rd_o,
    output logic               mem_valid_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic [REG_AW-1:0]  mem_rd_o,
    output logic               wb_valid_o,
    output logic               wb_regwrite_o,
    output logic [1:0]         wb_sel_o,
    output logic [REG_AW-1:0]  wb_rd_o,
    output logic               illegal_o
);

    ctrl_t             id_ctrl;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic              id_illegal;

    ctrl_t             ex_p0;
    logic [REG_AW-1:0] ex_rd_p0;
    logic              illegal_p0;
    mem_ctrl_t         mem_p1;
    logic [REG_AW-1:0] mem_rd_p1;
    wb_ctrl_t          wb_p2;
    logic [REG_AW-1:0] wb_rd_p2;

    logic              hazard;
    logic              bubble;

    ctrl_decode #(.REG_AW(REG_AW)) u_decode (
        .opcode   (id_opcode_i),
        .rd       (id_rd_i),
        .ctrl     (id_ctrl),
        .uses_rs1 (id_uses_rs1),
        .uses_rs2 (id_uses_rs2),
        .illegal  (id_illegal)
    );

    // A load in EX whose result ID needs cannot be forwarded in time.
    assign hazard = id_valid_i & ex_p0.valid & ex_p0.mem_read & (ex_rd_p0 != '0) &
                    ((id_uses_rs1 & (id_rs1_i == ex_rd_p0)) |
                     (id_uses_rs2 & (id_rs2_i == ex_rd_p0)));
    assign stall_id_o = hazard & ~flush_i;
    assign bubble     = flush_i | hazard | ~id_valid_i | id_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_p0      <= CTRL_BUBBLE;
            ex_rd_p0   <= '0;
            illegal_p0 <= 1'b0;
            mem_p1     <= '0;
            mem_rd_p1  <= '0;
            wb_p2      <= '0;
            wb_rd_p2   <= '0;
        end else begin
            // ID -> EX
            ex_p0      <= bubble ? CTRL_BUBBLE : id_ctrl;
            ex_rd_p0   <= bubble ? '0 : id_rd_i;
            illegal_p0 <= ILLEGAL_TRAP & id_valid_i & id_illegal & ~flush_i;
            // EX -> MEM
            mem_p1     <= '{valid: ex_p0.valid, mem_read: ex_p0.mem_read,
                            mem_write: ex_p0.mem_write, regwrite: ex_p0.regwrite,
                            wb_sel: ex_p0.wb_sel};
            mem_rd_p1  <= ex_rd_p0;
            // MEM -> WB
            wb_p2      <= '{valid: mem_p1.valid, regwrite: mem_p1.regwrite,
                            wb_sel: mem_p1.wb_sel};
            wb_rd_p2   <= mem_rd_p1;
        end
    end

    assign ex_valid_o    = ex_p0.valid;
    assign ex_branch_o   = ex_p0.branch;
    assign ex_jump_o     = ex_p0.jump;
    assign ex_jalr_o     = ex_p0.jalr;
    assign ex_alusrc_o   = ex_p0.alusrc;
    assign ex_asel_pc_o  = ex_p0.asel_pc;
    assign ex_aluop_o    = ALUOP_W'(ex_p0.aluop);
    assign ex_rd_o       = ex_rd_p0;
    assign illegal_o     = illegal_p0;

    assign mem_valid_o   = mem_p1.valid;
    assign mem_read_o    = mem_p1.mem_read;
    assign mem_write_o   = mem_p1.mem_write;
    assign mem_rd_o      = mem_rd_p1;

    assign wb_valid_o    = wb_p2.valid;
    assign wb_regwrite_o = wb_p2.regwrite;
    assign wb_sel_o      = wb_p2.wb_sel;
    assign wb_rd_o       = wb_rd_p2;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios followed by random
// instruction streams, compared against a table-driven pipeline model.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [6:0] opc = '0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       flush = 1'b0;

    logic       stall_id;
    logic       ex_valid, ex_branch, ex_jump, ex_jalr, ex_alusrc, ex_asel_pc;
    logic [1:0] ex_aluop;
    logic [4:0] ex_rd;
    logic       mem_valid, mem_read, mem_write;
    logic [4:0] mem_rd;
    logic       wb_valid, wb_regwrite;
    logic [1:0] wb_sel;
    logic [4:0] wb_rd;
    logic       illegal;

    int errors = 0;
    int checks = 0;

    ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_opcode_i(opc),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd), .flush_i(flush),
        .stall_id_o(stall_id), .ex_valid_o(ex_valid), .ex_branch_o(ex_branch),
        .ex_jump_o(ex_jump), .ex_jalr_o(ex_jalr), .ex_alusrc_o(ex_alusrc),
        .ex_asel_pc_o(ex_asel_pc), .ex_aluop_o(ex_aluop), .ex_rd_o(ex_rd),
        .mem_valid_o(mem_valid), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_rd_o(mem_rd), .wb_valid_o(wb_valid), .wb_regwrite_o(wb_regwrite),
        .wb_sel_o(wb_sel), .wb_rd_o(wb_rd), .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       vld, br, jmp, jalr, mr, mw;
        bit [1:0] sel, aluop;
        bit       asrc, apc, rw;
        bit [4:0] rd;
        bit       u1, u2, legal;
    } m_t;

    m_t ex_m, mem_m, wb_m;
    bit ill_m;
    bit stall_m;

    function automatic m_t empty_m();
        m_t m;
        m = '{default: 0};
        return m;
    endfunction

    // Decode table straight from the instruction-class list.
    function automatic m_t ref_decode(input logic [6:0] o, input logic [4:0] r);
        m_t m;
        m = '{default: 0};
        m.legal = 1'b1;
        case (o)
            7'b0110011: {m.br,m.jmp,m.jalr,m.mr,m.mw,m.sel,m.aluop,m.asrc,m.apc,m.rw,m.u1,m.u2} = 14'b0_0_0_0_0_00_10_0_0_1_1_1;
            7'b0010011: {m.br,m.jmp,m.jalr,m.mr,m.mw,m.sel,m.aluop,m.asrc,m.apc,m.rw,m.u1,m.u2} = 14'b0_0_0_0_0_00_10_1_0_1_1_0;
            7'b0000011: {m.br,m.jmp,m.jalr,m.mr,m.mw,m.sel,m.aluop,m.asrc,m.apc,m.rw,m.u1,m.u2} = 14'b0_0_0_1_0_01_00_1_0_1_1_0;
            7'b0100011: {m.br,m.jmp,m.jalr,m.mr,m.mw,m.sel,m.aluop,m.asrc,m.apc,m.rw,m.u1,m.u2} = 14'b0_0_0_0_1_00_00_1_0_0_1_1;
            7'b1100011: {m.br,m.jmp,m.jalr,m.mr,m.mw,m.sel,m.aluop,m.asrc,m.apc,m.rw,m.u1,m.u2} = 14'b1_0_0_0_0_00_01_0_0_0_1_1;
            7'b1101111: {m.br,m.jmp,m.jalr,m.mr,m.mw,m.sel,m.aluop,m.asrc,m.apc,m.rw,m.u1,m.u2} = 14'b0_1_0_0_0_10_00_1_1_1_0_0;
            7'b1100111: {m.br,m.jmp,m.jalr,m.mr,m.mw,m.sel,m.aluop,m.asrc,m.apc,m.rw,m.u1,m.u2} = 14'b0_1_1_0_0_10_00_1_0_1_1_0;
            7'b0110111: {m.br,m.jmp,m.jalr,m.mr,m.mw,m.sel,m.aluop,m.asrc,m.apc,m.rw,m.u1,m.u2} = 14'b0_0_0_0_0_00_11_1_0_1_0_0;
            7'b0010111: {m.br,m.jmp,m.jalr,m.mr,m.mw,m.sel,m.aluop,m.asrc,m.apc,m.rw,m.u1,m.u2} = 14'b0_0_0_0_0_00_00_1_1_1_0_0;
            default:    m.legal = 1'b0;
        endcase
        if (m.legal) begin
            m.vld = 1'b1;
            m.rd  = r;
            if (r == 5'd0) m.rw = 1'b0;
        end
        return m;
    endfunction

    function automatic bit ref_hazard();
        m_t d;
        d = ref_decode(opc, rd);
        return id_valid && ex_m.vld && ex_m.mr && (ex_m.rd != 5'd0) &&
               ((d.u1 && rs1 == ex_m.rd) || (d.u2 && rs2 == ex_m.rd));
    endfunction

    // Model of one clock edge: shift the three stages and admit ID or a bubble.
    function automatic void model_edge();
        m_t d;
        bit hz;
        d  = ref_decode(opc, rd);
        hz = ref_hazard();
        ill_m = id_valid && !d.legal && !flush;
        wb_m  = mem_m;
        mem_m = ex_m;
        ex_m  = (flush || hz || !id_valid || !d.legal) ? empty_m() : d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":ex"},
            32'({ex_valid, ex_branch, ex_jump, ex_jalr, ex_alusrc, ex_asel_pc, ex_aluop, ex_rd}),
            32'({ex_m.vld, ex_m.br, ex_m.jmp, ex_m.jalr, ex_m.asrc, ex_m.apc, ex_m.aluop, ex_m.rd}));
        chk({tag, ":mem"}, 32'({mem_valid, mem_read, mem_write, mem_rd}),
            32'({mem_m.vld, mem_m.mr, mem_m.mw, mem_m.rd}));
        chk({tag, ":wb"}, 32'({wb_valid, wb_regwrite, wb_sel, wb_rd}),
            32'({wb_m.vld, wb_m.rw, wb_m.sel, wb_m.rd}));
        chk({tag, ":illegal"}, 32'(illegal), 32'(ill_m));
    endtask

    task automatic step(input string tag, input bit v, input logic [6:0] o,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] r,
                        input bit f);
        @(negedge clk);
        id_valid = v; opc = o; rs1 = a; rs2 = b; rd = r; flush = f;
        #1;
        stall_m = ref_hazard() && !flush;
        chk({tag, ":stall"}, 32'(stall_id), 32'(stall_m));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    logic [6:0] ops [10];
    logic [6:0] c_op;
    logic [4:0] c_rs1, c_rs2, c_rd;
    bit         c_v;

    initial begin
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        ex_m = empty_m(); mem_m = empty_m(); wb_m = empty_m(); ill_m = 1'b0;

        #1;
        check_outputs("reset");
        chk("reset:stall", 32'(stall_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step("lui", 1'b1, 7'b0110111, 5'd0, 5'd0, 5'd5, 1'b0);
        chk("lui:aluop", 32'(ex_aluop), 32'd3);
        chk("lui:asel_pc", 32'(ex_asel_pc), 32'd0);
        idle("lui+1");
        idle("lui+2");
        chk("lui:wb", 32'({wb_regwrite, wb_sel, wb_rd}), 32'({1'b1, 2'b00, 5'd5}));

        step("lw3", 1'b1, 7'b0000011, 5'd1, 5'd0, 5'd3, 1'b0);
        step("add_stall", 1'b1, 7'b0110011, 5'd3, 5'd4, 5'd7, 1'b0);
        chk("ldu:stall_seen", 32'(stall_m), 32'd1);
        chk("ldu:bubble", 32'(ex_valid), 32'd0);
        step("add_go", 1'b1, 7'b0110011, 5'd3, 5'd4, 5'd7, 1'b0);
        chk("ldu:released", 32'({stall_m, ex_valid, ex_rd}), 32'({1'b0, 1'b1, 5'd7}));

        step("lw0", 1'b1, 7'b0000011, 5'd1, 5'd0, 5'd0, 1'b0);
        step("add_x0", 1'b1, 7'b0110011, 5'd0, 5'd0, 5'd8, 1'b0);
        chk("x0:no_stall", 32'(stall_m), 32'd0);
        step("lw3b", 1'b1, 7'b0000011, 5'd1, 5'd0, 5'd3, 1'b0);
        step("jal", 1'b1, 7'b1101111, 5'd3, 5'd3, 5'd1, 1'b0);
        chk("jal:no_stall", 32'(stall_m), 32'd0);

        step("lw3c", 1'b1, 7'b0000011, 5'd1, 5'd0, 5'd3, 1'b0);
        step("hz_flush", 1'b1, 7'b0110011, 5'd3, 5'd3, 5'd9, 1'b1);
        chk("flush:stall", 32'(stall_m), 32'd0);
        chk("flush:ex", 32'(ex_valid), 32'd0);
        chk("flush:memread", 32'(mem_read), 32'd1);

        step("jalr", 1'b1, 7'b1100111, 5'd2, 5'd0, 5'd1, 1'b0);
        chk("jalr:ex", 32'({ex_jump, ex_jalr}), 32'b11);
        idle("jalr+1");
        idle("jalr+2");
        chk("jalr:wb", 32'({wb_sel, wb_regwrite}), 32'({2'b10, 1'b1}));

        step("illegal", 1'b1, 7'b1111111, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("illegal:pulse", 32'({illegal, ex_valid}), 32'b10);
        idle("illegal+1");
        chk("illegal:once", 32'(illegal), 32'd0);

        step("r1", 1'b1, 7'b0110011, 5'd1, 5'd2, 5'd10, 1'b0);
        step("r2", 1'b1, 7'b0110011, 5'd4, 5'd5, 5'd11, 1'b0);
        step("r3", 1'b1, 7'b0110011, 5'd6, 5'd7, 5'd12, 1'b0);
        #2;
        id_valid = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #1;
        ex_m = empty_m(); mem_m = empty_m(); wb_m = empty_m(); ill_m = 1'b0;
        check_outputs("async_rst");
        chk("async_rst:stall", 32'(stall_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step("store", 1'b1, 7'b0100011, 5'd1, 5'd2, 5'd13, 1'b0);
        idle("store+1");
        chk("store:memwrite", 32'(mem_write), 32'd1);
        idle("store+2");
        chk("store:wb", 32'({wb_valid, wb_regwrite}), 32'b10);

        c_v = 1'b0; c_op = '0; c_rs1 = '0; c_rs2 = '0; c_rd = '0;
        stall_m = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!stall_m) begin
                c_v   = ($urandom_range(0, 5) != 0);
                c_op  = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 9)];
                c_rs1 = 5'($urandom_range(0, 3));
                c_rs2 = 5'($urandom_range(0, 3));
                c_rd  = 5'($urandom_range(0, 3));
            end
            step("rand", c_v, c_op, c_rs1, c_rs2, c_rd, ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
